lap_stopwatch: RTL and testbench

- Parametrised stopwatch/timer with hours, minutes, seconds and milliseconds.
- A clock prescaler generates 1 ms ticks.
- Command-driven FSM supports run, pause, resume and clear.
- Supports count-up or count-down (countdown timer) mode, with preset load, lap capture, wrap-overflow flag and a countdown-done pulse.
- Sits between button debouncers/edge detectors and display drivers.

---
 rtl/lap_stopwatch.sv | 199 +++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_stopwatch.sv
// Stopwatch / countdown timer (hr:min:sec.ms) driven by single-cycle commands.
// A prescaler turns TICK_DIV clk cycles into one 1 ms tick while running.
module lap_stopwatch #(
   parameter int TICK_DIV = 1,
   parameter int HR_W     = 5,
   parameter int HR_MAX   = 23
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            stop,
   input  logic            clear,
   input  logic            lap,
   input  logic            load,
   input  logic            mode_down,
   input  logic [9:0]      preset_ms,
   input  logic [5:0]      preset_sec,
   input  logic [5:0]      preset_min,
   input  logic [HR_W-1:0] preset_hr,
   output logic [9:0]      ms,
   output logic [5:0]      sec,
   output logic [5:0]      min,
   output logic [HR_W-1:0] hr,
   output logic [9:0]      lap_ms,
   output logic [5:0]      lap_sec,
   output logic [5:0]      lap_min,
   output logic [HR_W-1:0] lap_hr,
   output logic            lap_valid,
   output logic            running,
   output logic            paused,
   output logic            done,
   output logic            overflow
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRE_TOP = PW'(TICK_DIV - 1);
   localparam logic [HR_W-1:0] HR_TOP  = HR_W'(HR_MAX);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t          state;
   logic [PW-1:0]   presc;
   logic            dir;

   logic            tick, at_zero, dn_zero;
   logic            c_ms, c_sec, c_min, wrap;
   logic            b_ms, b_sec, b_min;
   logic [9:0]      ms_up, ms_dn, ld_ms;
   logic [5:0]      sec_up, sec_dn, ld_sec;
   logic [5:0]      min_up, min_dn, ld_min;
   logic [HR_W-1:0] hr_up, hr_dn, ld_hr;

   always_comb begin
      tick    = (state == RUN) && (presc == PRE_TOP);
      at_zero = (ms == 10'd0) && (sec == 6'd0) && (min == 6'd0) && (hr == '0);

      // Up count: carries cascade through every field within one tick
      c_ms   = (ms == 10'd999);
      c_sec  = c_ms && (sec == 6'd59);
      c_min  = c_sec && (min == 6'd59);
      wrap   = c_min && (hr == HR_TOP);
      ms_up  = c_ms ? 10'd0 : ms + 10'd1;
      sec_up = c_ms ? ((sec == 6'd59) ? 6'd0 : sec + 6'd1) : sec;
      min_up = c_sec ? ((min == 6'd59) ? 6'd0 : min + 6'd1) : min;
      hr_up  = c_min ? (wrap ? '0 : hr + HR_W'(1)) : hr;

      // Down count: only used when not already at zero, so hr never underflows
      b_ms    = (ms == 10'd0);
      b_sec   = b_ms && (sec == 6'd0);
      b_min   = b_sec && (min == 6'd0);
      ms_dn   = b_ms ? 10'd999 : ms - 10'd1;
      sec_dn  = b_ms ? ((sec == 6'd0) ? 6'd59 : sec - 6'd1) : sec;
      min_dn  = b_sec ? ((min == 6'd0) ? 6'd59 : min - 6'd1) : min;
      hr_dn   = b_min ? hr - HR_W'(1) : hr;
      dn_zero = (ms_dn == 10'd0) && (sec_dn == 6'd0) && (min_dn == 6'd0) && (hr_dn == '0);

      ld_ms  = (preset_ms > 10'd999) ? 10'd999 : preset_ms;
      ld_sec = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
      ld_min = (preset_min > 6'd59) ? 6'd59 : preset_min;
      ld_hr  = (preset_hr > HR_TOP) ? HR_TOP : preset_hr;
   end

   assign running = (state == RUN);
   assign paused  = (state == PAUSE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         presc     <= '0;
         dir       <= 1'b0;
         ms        <= '0;
         sec       <= '0;
         min       <= '0;
         hr        <= '0;
         lap_ms    <= '0;
         lap_sec   <= '0;
         lap_min   <= '0;
         lap_hr    <= '0;
         lap_valid <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         lap_valid <= 1'b0;
         done      <= 1'b0;
         if (clear) begin
            state    <= IDLE;
            presc    <= '0;
            ms       <= '0;
            sec      <= '0;
            min      <= '0;
            hr       <= '0;
            lap_ms   <= '0;
            lap_sec  <= '0;
            lap_min  <= '0;
            lap_hr   <= '0;
            overflow <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (load) begin
                     ms    <= ld_ms;
                     sec   <= ld_sec;
                     min   <= ld_min;
                     hr    <= ld_hr;
                     presc <= '0;
                  end else if (start && !(mode_down && at_zero)) begin
                     state <= RUN;
                     dir   <= mode_down;
                     presc <= '0;
                  end
               end
               RUN: begin
                  // Lap sees the pre-edge counters; stop outranks it
                  if (lap && !stop) begin
                     lap_ms    <= ms;
                     lap_sec   <= sec;
                     lap_min   <= min;
                     lap_hr    <= hr;
                     lap_valid <= 1'b1;
                  end
                  if (stop)
                     state <= PAUSE;
                  presc <= tick ? '0 : presc + PW'(1);
                  if (tick) begin
                     if (!dir) begin
                        ms  <= ms_up;
                        sec <= sec_up;
                        min <= min_up;
                        hr  <= hr_up;
                        if (wrap)
                           overflow <= 1'b1;
                     end else begin
                        if (!at_zero) begin
                           ms  <= ms_dn;
                           sec <= sec_dn;
                           min <= min_dn;
                           hr  <= hr_dn;
                        end
                        // Reaching zero overrides a simultaneous stop
                        if (at_zero || dn_zero) begin
                           state <= DONE;
                           done  <= 1'b1;
                           presc <= '0;
                        end
                     end
                  end
               end
               PAUSE: begin
                  if (load) begin
                     ms    <= ld_ms;
                     sec   <= ld_sec;
                     min   <= ld_min;
                     hr    <= ld_hr;
                     presc <= '0;
                  end else if (!stop && start) begin
                     state <= RUN;
                  end else if (!stop && lap) begin
                     lap_ms    <= ms;
                     lap_sec   <= sec;
                     lap_min   <= min;
                     lap_hr    <= hr;
                     lap_valid <= 1'b1;
                  end
               end
               DONE: begin
                  if (load) begin
                     ms    <= ld_ms;
                     sec   <= ld_sec;
                     min   <= ld_min;
                     hr    <= ld_hr;
                     presc <= '0;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: two instances (TICK_DIV=1/HR_MAX=1 and TICK_DIV=4/HR_MAX=23)
// checked every cycle against a total-milliseconds reference model.
module tb_lap_stopwatch;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

   logic       clk = 1'b0;
   logic       reset, start, stop, clear, lap, load, mode_down;
   logic [9:0] preset_ms;
   logic [5:0] preset_sec, preset_min;
   logic [4:0] preset_hr;

   logic [9:0] a_ms, a_lap_ms, b_ms, b_lap_ms;
   logic [5:0] a_sec, a_min, a_lap_sec, a_lap_min, b_sec, b_min, b_lap_sec, b_lap_min;
   logic [4:0] a_hr, a_lap_hr, b_hr, b_lap_hr;
   logic       a_lap_valid, a_running, a_paused, a_done, a_overflow;
   logic       b_lap_valid, b_running, b_paused, b_done, b_overflow;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     td[2]    = '{1, 4};
   int     hm[2]    = '{1, 23};
   int     m_st[2], m_phase[2];
   longint m_t[2], m_lap[2];
   bit     m_dir[2], m_ovf[2], m_lapv[2], m_done[2];
   int     done_cnt;

   always #5 clk = ~clk;

   lap_stopwatch #(.TICK_DIV(1), .HR_W(5), .HR_MAX(1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
      .load(load), .mode_down(mode_down), .preset_ms(preset_ms), .preset_sec(preset_sec),
      .preset_min(preset_min), .preset_hr(preset_hr), .ms(a_ms), .sec(a_sec), .min(a_min),
      .hr(a_hr), .lap_ms(a_lap_ms), .lap_sec(a_lap_sec), .lap_min(a_lap_min), .lap_hr(a_lap_hr),
      .lap_valid(a_lap_valid), .running(a_running), .paused(a_paused), .done(a_done),
      .overflow(a_overflow));

   lap_stopwatch #(.TICK_DIV(4), .HR_W(5), .HR_MAX(23)) dut_b (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
      .load(load), .mode_down(mode_down), .preset_ms(preset_ms), .preset_sec(preset_sec),
      .preset_min(preset_min), .preset_hr(preset_hr), .ms(b_ms), .sec(b_sec), .min(b_min),
      .hr(b_hr), .lap_ms(b_lap_ms), .lap_sec(b_lap_sec), .lap_min(b_lap_min), .lap_hr(b_lap_hr),
      .lap_valid(b_lap_valid), .running(b_running), .paused(b_paused), .done(b_done),
      .overflow(b_overflow));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack_time(input longint t);
      longint h, mi, s, m;
      m  = t % 1000;
      s  = (t / 1000) % 60;
      mi = (t / 60000) % 60;
      h  = t / 3600000;
      return 64'((h << 22) | (mi << 16) | (s << 10) | m);
   endfunction

   function automatic longint preset_total(input int i);
      longint pm, ps, pn, ph;
      pm = (preset_ms > 999) ? 999 : longint'(preset_ms);
      ps = (preset_sec > 59) ? 59 : longint'(preset_sec);
      pn = (preset_min > 59) ? 59 : longint'(preset_min);
      ph = (int'(preset_hr) > hm[i]) ? longint'(hm[i]) : longint'(preset_hr);
      return ((ph * 60 + pn) * 60 + ps) * 1000 + pm;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = S_IDLE; m_t[i] = 0; m_lap[i] = 0; m_phase[i] = 0;
         m_dir[i] = 0; m_ovf[i] = 0; m_lapv[i] = 0; m_done[i] = 0;
      end
   endtask

   // Time kept as total milliseconds; the field split happens only at compare time
   task automatic model_step(input int i);
      longint lim;
      bit     tk;
      lim = longint'(hm[i] + 1) * 3600000;
      m_lapv[i] = 0;
      m_done[i] = 0;
      if (clear) begin
         m_st[i] = S_IDLE; m_t[i] = 0; m_lap[i] = 0; m_phase[i] = 0; m_ovf[i] = 0;
      end else begin
         case (m_st[i])
            S_IDLE: begin
               if (load) begin
                  m_t[i] = preset_total(i); m_phase[i] = 0;
               end else if (start && !(mode_down && m_t[i] == 0)) begin
                  m_st[i] = S_RUN; m_dir[i] = mode_down; m_phase[i] = 0;
               end
            end
            S_RUN: begin
               if (lap && !stop) begin m_lap[i] = m_t[i]; m_lapv[i] = 1; end
               tk = (m_phase[i] == td[i] - 1);
               m_phase[i] = tk ? 0 : m_phase[i] + 1;
               if (stop) m_st[i] = S_PAUSE;
               if (tk) begin
                  if (!m_dir[i]) begin
                     m_t[i] = m_t[i] + 1;
                     if (m_t[i] == lim) begin m_t[i] = 0; m_ovf[i] = 1; end
                  end else begin
                     if (m_t[i] > 0) m_t[i] = m_t[i] - 1;
                     if (m_t[i] == 0) begin m_st[i] = S_DONE; m_done[i] = 1; m_phase[i] = 0; end
                  end
               end
            end
            S_PAUSE: begin
               if (load) begin
                  m_t[i] = preset_total(i); m_phase[i] = 0;
               end else if (stop) begin
               end else if (start) begin
                  m_st[i] = S_RUN;
               end else if (lap) begin
                  m_lap[i] = m_t[i]; m_lapv[i] = 1;
               end
            end
            default: begin
               if (load) begin m_t[i] = preset_total(i); m_phase[i] = 0; m_st[i] = S_IDLE; end
            end
         endcase
      end
   endtask

   function automatic logic [63:0] exp_flags(input int i);
      return 64'({m_lapv[i], m_st[i] == S_RUN, m_st[i] == S_PAUSE, m_done[i], m_ovf[i]});
   endfunction

   task automatic compare_all();
      check("a_time",  64'({a_hr, a_min, a_sec, a_ms}), pack_time(m_t[0]));
      check("a_lap",   64'({a_lap_hr, a_lap_min, a_lap_sec, a_lap_ms}), pack_time(m_lap[0]));
      check("a_flags", 64'({a_lap_valid, a_running, a_paused, a_done, a_overflow}), exp_flags(0));
      check("b_time",  64'({b_hr, b_min, b_sec, b_ms}), pack_time(m_t[1]));
      check("b_lap",   64'({b_lap_hr, b_lap_min, b_lap_sec, b_lap_ms}), pack_time(m_lap[1]));
      check("b_flags", 64'({b_lap_valid, b_running, b_paused, b_done, b_overflow}), exp_flags(1));
   endtask

   // Called at a negedge: drive commands, let one posedge happen, compare at next negedge
   task automatic cyc(input bit c_start, input bit c_stop, input bit c_clear,
                      input bit c_lap, input bit c_load);
      start = c_start; stop = c_stop; clear = c_clear; lap = c_lap; load = c_load;
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_preset(input int h, input int mi, input int s, input int m);
      preset_hr = 5'(h); preset_min = 6'(mi); preset_sec = 6'(s); preset_ms = 10'(m);
   endtask

   initial begin
      reset = 1'b1; start = 0; stop = 0; clear = 0; lap = 0; load = 0; mode_down = 0;
      set_preset(0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      compare_all();
      check("reset_a_ms", 64'(a_ms), 64'd0);
      $display("reset state checked");

      // Up count with TICK_DIV=1 and a minute carry
      cyc(1, 0, 0, 0, 0);
      repeat (1000) cyc(0, 0, 0, 0, 0);
      check("up1000_ms", 64'(a_ms), 64'd0);
      check("up1000_sec", 64'(a_sec), 64'd1);
      cyc(0, 1, 0, 0, 0);
      set_preset(0, 0, 59, 999);
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      check("carry_min", 64'({a_min, a_sec, a_ms}), 64'({6'd1, 6'd0, 10'd0}));
      $display("up count and minute carry checked");

      // Prescaler latency and pause/resume with TICK_DIV=4
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      repeat (3) begin
         cyc(0, 0, 0, 0, 0);
         check("div4_pre_ms", 64'(b_ms), 64'd0);
      end
      cyc(0, 0, 0, 0, 0);
      check("div4_first_ms", 64'(b_ms), 64'd1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      repeat (10) cyc(0, 0, 0, 0, 0);
      check("div4_pause_ms", 64'({b_paused, b_ms}), 64'({1'b1, 10'd1}));
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      check("div4_resume1", 64'(b_ms), 64'd1);
      cyc(0, 0, 0, 0, 0);
      check("div4_resume2", 64'(b_ms), 64'd2);
      $display("prescaler pause/resume checked");

      // Overflow wrap with HR_MAX=1
      cyc(0, 0, 1, 0, 0);
      set_preset(1, 59, 59, 998);
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      check("wrap_time", 64'({a_hr, a_min, a_sec, a_ms}), 64'd0);
      check("wrap_ovf", 64'(a_overflow), 64'd1);
      repeat (3) cyc(0, 0, 0, 0, 0);
      check("ovf_sticky", 64'(a_overflow), 64'd1);
      cyc(0, 0, 1, 0, 0);
      check("ovf_clear", 64'(a_overflow), 64'd0);
      $display("overflow wrap checked");

      // Countdown to done
      set_preset(0, 0, 1, 2);
      cyc(0, 0, 0, 0, 1);
      mode_down = 1'b1;
      cyc(1, 0, 0, 0, 0);
      done_cnt = 0;
      repeat (1001) begin
         cyc(0, 0, 0, 0, 0);
         done_cnt += int'(a_done);
      end
      check("down_last_ms", 64'({a_done, a_ms}), 64'({1'b0, 10'd1}));
      cyc(0, 0, 0, 0, 0);
      done_cnt += int'(a_done);
      check("down_zero", 64'({a_done, a_running, a_hr, a_min, a_sec, a_ms}), 64'({1'b1, 1'b0, 27'd0}));
      repeat (3) begin
         cyc(0, 0, 0, 0, 0);
         done_cnt += int'(a_done);
      end
      check("done_pulses", 64'(done_cnt), 64'd1);
      cyc(1, 0, 0, 0, 0);
      check("done_start_ign", 64'({a_running, a_ms}), 64'd0);
      $display("countdown done checked");

      // Lap capture and load ignored in RUN
      mode_down = 1'b0;
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      repeat (37) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      check("lap_ms", 64'({a_lap_valid, a_lap_ms, a_ms}), 64'({1'b1, 10'd37, 10'd38}));
      cyc(0, 0, 0, 0, 0);
      check("lap_valid_off", 64'(a_lap_valid), 64'd0);
      set_preset(0, 0, 0, 5);
      cyc(0, 0, 0, 0, 1);
      check("load_in_run", 64'({a_running, a_ms}), 64'({1'b1, 10'd40}));
      $display("lap capture checked");

      // clear beats start in RUN
      cyc(1, 0, 1, 0, 0);
      check("clear_start", 64'({a_running, a_ms, b_running, b_ms}), 64'd0);

      // Reset between clock edges
      cyc(1, 0, 0, 0, 0);
      repeat (5) cyc(0, 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      check("async_rst", 64'({a_running, a_ms, b_running, b_ms}), 64'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      compare_all();
      $display("clear and async reset checked");

      // Random commands against the model
      for (int n = 0; n < 4000; n++) begin
         mode_down = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0)
            set_preset(0, 0, 0, int'($urandom_range(0, 30)));
         else
            set_preset(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                       int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)));
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
      end
      $display("random phase done");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
